// File: rtl/modulo_counter_fsm_pkg.sv
// Shared state encodings and state type for the modulo up/down counter.
package modulo_counter_fsm_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] STATE_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] STATE_UP   = 2'd1;
    localparam logic [STATE_W-1:0] STATE_DOWN = 2'd2;
    localparam logic [STATE_W-1:0] STATE_HOLD = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = STATE_IDLE,
        ST_UP   = STATE_UP,
        ST_DOWN = STATE_DOWN,
        ST_HOLD = STATE_HOLD
    } state_e;

    // Direction-selected run state.
    function automatic state_e run_state(input logic up_down);
        return up_down ? ST_UP : ST_DOWN;
    endfunction

endpackage

// File: rtl/ripple_addsub_n.sv
// WIDTH-bit ripple-carry adder; sub=1 computes a - b as a + ~b + 1.
module ripple_addsub_n #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] carry;

    assign b_eff    = b ^ {WIDTH{sub}};
    assign carry[0] = sub;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum[i] = a[i] ^ b_eff[i] ^ carry[i];
        // The carry out of the top bit is discarded: results wrap modulo 2^WIDTH.
        if (i < WIDTH - 1) begin : g_carry
            assign carry[i+1] = (a[i] & b_eff[i]) | (carry[i] & (a[i] ^ b_eff[i]));
        end
    end

endmodule

// File: rtl/modulo_counter_fsm.sv
// Up/down modulo counter over 0..limit with saturating load, wrap pulse and IDLE/UP/DOWN/HOLD FSM.
module modulo_counter_fsm
    import modulo_counter_fsm_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             terminal,
    output logic             wrapped,
    output logic [1:0]       state
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrapped_q, wrapped_d;
    logic [WIDTH-1:0] step_sum;
    logic [WIDTH-1:0] load_sat;
    logic             at_top;
    logic             at_bottom;

    // Single shared incrementer/decrementer; direction follows the live up_down input.
    ripple_addsub_n #(
        .WIDTH(WIDTH)
    ) u_step (
        .a   (count_q),
        .b   (WIDTH'(1)),
        .sub (~up_down),
        .sum (step_sum)
    );

    // count above a lowered limit counts as terminal when going up only.
    assign at_top    = (count_q >= limit);
    assign at_bottom = (count_q == '0);
    assign terminal  = up_down ? at_top : at_bottom;
    assign load_sat  = (load_value > limit) ? limit : load_value;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        wrapped_d = 1'b0;

        if (load) begin
            count_d = load_sat;
            state_d = enable ? run_state(up_down) : ST_HOLD;
        end else if (enable) begin
            state_d = run_state(up_down);
            if (terminal) begin
                count_d   = up_down ? '0 : limit;
                wrapped_d = 1'b1;
            end else begin
                count_d = step_sum;
            end
        end else if (state_q == ST_UP || state_q == ST_DOWN) begin
            state_d = ST_HOLD;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= WIDTH'(RESET_VAL);
            wrapped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            wrapped_q <= wrapped_d;
        end
    end

    assign count   = count_q;
    assign wrapped = wrapped_q;
    assign state   = state_q;

endmodule
